// File: rtl/apb_completer.sv
// ---------------------------------------------------------------------------
// apb_completer
//
// APB completer serving a bank of 32-bit word registers. A transfer is
// captured on its setup edge, held for WAIT_STATES access cycles, then
// completed with a one-cycle pready pulse. Misaligned or out-of-range
// addresses, and requester protocol violations seen during the wait, are
// reported on pslverr. Errored transfers never touch the register bank.
//
// Ports
//   pclk      in   clock, all logic on rising edge
//   preset    in   synchronous active-high reset
//   psel      in   completer select
//   penable   in   access-phase indicator
//   pwrite    in   1 = write, 0 = read
//   paddr     in   byte address, register i at 4*i
//   pwdata    in   write data
//   pstrb     in   write byte strobes
//   prdata    out  read data, non-zero only while pready = 1
//   pready    out  completion pulse, exactly one cycle per transfer
//   pslverr   out  error response, valid only while pready = 1
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a setup phase (psel=1, penable=0)
// WAIT  | access phase, counting wait states, checking protocol
// DONE  | pready high; next edge is the completion edge (write commit)
// ---------------------------------------------------------------------------
module apb_completer #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int NUM_REGS    = 16,
   parameter int WAIT_STATES = 1
) (
   input  logic                      pclk,
   input  logic                      preset,
   input  logic                      psel,
   input  logic                      penable,
   input  logic                      pwrite,
   input  logic [ADDR_WIDTH-1:0]     paddr,
   input  logic [DATA_WIDTH-1:0]     pwdata,
   input  logic [DATA_WIDTH/8-1:0]   pstrb,
   output logic [DATA_WIDTH-1:0]     prdata,
   output logic                      pready,
   output logic                      pslverr
);

   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

   localparam logic [ADDR_WIDTH-3:0] REG_LIMIT = (ADDR_WIDTH-2)'(NUM_REGS);
   localparam logic [3:0]            CNT_INIT  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]            state_q,   state_d;
   logic [3:0]            cnt_q,     cnt_d;
   logic [ADDR_WIDTH-1:0] addr_q,    addr_d;
   logic                  write_q,   write_d;
   logic [DATA_WIDTH-1:0] wdata_q,   wdata_d;
   logic [STRB_W-1:0]     strb_q,    strb_d;
   logic                  err_q,     err_d;
   logic [DATA_WIDTH-1:0] prdata_q,  prdata_d;
   logic                  pready_q,  pready_d;
   logic                  pslverr_q, pslverr_d;

   logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

   logic                  setup;
   logic                  addr_err_in;
   logic                  proto_err;
   logic                  wr_en;
   logic [IDX_W-1:0]      rd_idx;
   logic [IDX_W-1:0]      wr_idx;

   assign setup       = psel & ~penable;
   assign addr_err_in = (paddr[1:0] != 2'b00) | (paddr[ADDR_WIDTH-1:2] >= REG_LIMIT);
   assign proto_err   = ~psel | ~penable | (paddr != addr_q) | (pwrite != write_q);

   // With zero wait states DONE is entered straight from IDLE, so the read
   // index has to come from the live bus instead of the captured address.
   assign rd_idx = (state_q == ST_IDLE) ? paddr[IDX_W+1:2] : addr_q[IDX_W+1:2];
   assign wr_idx = addr_q[IDX_W+1:2];

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      write_d   = write_q;
      wdata_d   = wdata_q;
      strb_d    = strb_q;
      err_d     = err_q;
      prdata_d  = prdata_q;
      pready_d  = pready_q;
      pslverr_d = pslverr_q;
      wr_en     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (setup) begin
               addr_d  = paddr;
               write_d = pwrite;
               wdata_d = pwdata;
               strb_d  = pstrb;
               err_d   = addr_err_in;
               if (WAIT_STATES == 0) begin
                  state_d   = ST_DONE;
                  pready_d  = 1'b1;
                  pslverr_d = addr_err_in;
                  prdata_d  = (!pwrite && !addr_err_in) ? regs_q[rd_idx] : '0;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = CNT_INIT;
               end
            end
         end

         ST_WAIT: begin
            err_d = err_q | proto_err;
            if (cnt_q == 4'd0) begin
               state_d   = ST_DONE;
               pready_d  = 1'b1;
               pslverr_d = err_d;
               prdata_d  = (!write_q && !err_d) ? regs_q[rd_idx] : '0;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end

         ST_DONE: begin
            state_d   = ST_IDLE;
            pready_d  = 1'b0;
            pslverr_d = 1'b0;
            prdata_d  = '0;
            // A requester that drops psel on the completion edge has
            // abandoned the transfer; nothing is written.
            wr_en     = write_q & ~err_q & psel & penable;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge pclk) begin
      if (preset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= 4'd0;
         addr_q    <= '0;
         write_q   <= 1'b0;
         wdata_q   <= '0;
         strb_q    <= '0;
         err_q     <= 1'b0;
         prdata_q  <= '0;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         write_q   <= write_d;
         wdata_q   <= wdata_d;
         strb_q    <= strb_d;
         err_q     <= err_d;
         prdata_q  <= prdata_d;
         pready_q  <= pready_d;
         pslverr_q <= pslverr_d;
         for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_en && (wr_idx == IDX_W'(i))) begin
               for (int b = 0; b < STRB_W; b++) begin
                  if (strb_q[b]) begin
                     regs_q[i][8*b +: 8] <= wdata_q[8*b +: 8];
                  end
               end
            end
         end
      end
   end

   assign prdata  = prdata_q;
   assign pready  = pready_q;
   assign pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_completer.sv
// ---------------------------------------------------------------------------
// tb_apb_completer
//
// Drives APB transfers (directed then random) into apb_completer. Each issued
// transfer pushes its expected response into a queue, computed from a plain
// word-array model of the register bank; a monitor pops and compares on every
// pready pulse and checks outputs stay zero otherwise.
// ---------------------------------------------------------------------------
module tb_apb_completer;

   localparam int WS = 1;
   localparam int NR = 16;

   logic        pclk = 1'b0;
   logic        preset;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [31:0] paddr;
   logic [31:0] pwdata;
   logic [3:0]  pstrb;
   logic [31:0] prdata;
   logic        pready;
   logic        pslverr;

   apb_completer #(
      .ADDR_WIDTH  (32),
      .DATA_WIDTH  (32),
      .NUM_REGS    (NR),
      .WAIT_STATES (WS)
   ) dut (
      .pclk    (pclk),
      .preset  (preset),
      .psel    (psel),
      .penable (penable),
      .pwrite  (pwrite),
      .paddr   (paddr),
      .pwdata  (pwdata),
      .pstrb   (pstrb),
      .prdata  (prdata),
      .pready  (pready),
      .pslverr (pslverr)
   );

   always #5 pclk = ~pclk;

   int cyc = 0;
   always @(posedge pclk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          e0;
   } exp_t;

   exp_t        exp_q[$];
   int          checks   = 0;
   int          failures = 0;
   logic [31:0] model [NR];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %h required %h (t=%0t)", nm, act, req, $time);
      end
   endtask

   // monitor
   always @(negedge pclk) begin
      if (preset !== 1'b1) begin
         if (pready === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_pready: got pready=1 with no transfer outstanding (t=%0t)", $time);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("prdata", prdata, e.rdata);
               check("pslverr", {31'd0, pslverr}, {31'd0, e.err});
               check("latency", cyc, e.e0 + WS);
            end
         end else begin
            check("idle_prdata", prdata, 32'd0);
            check("idle_pslverr", {31'd0, pslverr}, 32'd0);
         end
      end
   end

   // mode 0: normal, 1: psel dropped in access phase, 2: psel dropped on
   // completion edge, 3: paddr changed in access phase
   task automatic do_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int mode);
      exp_t e;
      bit   aerr;
      bit   err;
      int   idx;
      int   n;
      aerr = (addr[1:0] != 2'b00) || ((addr >> 2) >= NR);
      err  = aerr || (((mode == 1) || (mode == 3)) && (WS > 0));
      idx  = int'(addr >> 2);
      e.err   = err;
      e.rdata = 32'd0;
      if (!wr && !err) e.rdata = model[idx];
      e.e0 = cyc + 1;
      exp_q.push_back(e);
      if (wr && !err && ((mode == 0) || (mode == 3))) begin
         for (int b = 0; b < 4; b++) begin
            if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
         end
      end

      psel    = 1'b1;
      penable = 1'b0;
      pwrite  = wr;
      paddr   = addr;
      pwdata  = data;
      pstrb   = strb;
      @(posedge pclk); #1;
      penable = 1'b1;
      if (mode == 1) psel = 1'b0;
      if (mode == 3) paddr = addr ^ 32'h4;
      n = 0;
      do begin
         @(negedge pclk);
         n++;
      end while ((pready !== 1'b1) && (n < 20));
      if (pready !== 1'b1) begin
         checks++;
         failures++;
         $display("FAIL pready_timeout: got no pready after %0d cycles, required within %0d", n, WS + 1);
      end
      if (mode == 2) psel = 1'b0;
      @(posedge pclk); #1;
      psel    = 1'b0;
      penable = 1'b0;
   endtask

   task automatic idle(input int n);
      psel    = 1'b0;
      penable = 1'b0;
      repeat (n) begin
         @(posedge pclk); #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation still running, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] a;
      int          r;
      int          m;
      preset  = 1'b1;
      psel    = 1'b0;
      penable = 1'b0;
      pwrite  = 1'b0;
      paddr   = 32'd0;
      pwdata  = 32'd0;
      pstrb   = 4'd0;
      for (int i = 0; i < NR; i++) model[i] = 32'd0;
      repeat (3) @(posedge pclk);
      #1;
      preset = 1'b0;
      @(negedge pclk);
      check("rst_pready", {31'd0, pready}, 32'd0);
      check("rst_pslverr", {31'd0, pslverr}, 32'd0);
      check("rst_prdata", prdata, 32'd0);
      @(posedge pclk); #1;

      // full write then read back
      do_xfer(1, 32'h4, 32'hDEAD_BEEF, 4'hF, 0);
      do_xfer(0, 32'h4, 32'h0, 4'h0, 0);
      // partial write over zero
      do_xfer(1, 32'h8, 32'h1122_3344, 4'h5, 0);
      do_xfer(0, 32'h8, 32'h0, 4'h0, 0);
      // address errors, including writes that must not land
      do_xfer(0, 32'h3, 32'h0, 4'h0, 0);
      do_xfer(0, 32'h40, 32'h0, 4'h0, 0);
      do_xfer(1, 32'h40, 32'hFFFF_FFFF, 4'hF, 0);
      do_xfer(1, 32'h5, 32'hFFFF_FFFF, 4'hF, 0);
      do_xfer(0, 32'h4, 32'h0, 4'h0, 0);
      do_xfer(0, 32'h0, 32'h0, 4'h0, 0);
      // psel dropped with penable raised: error, no write
      do_xfer(1, 32'h4, 32'h5555_AAAA, 4'hF, 1);
      do_xfer(0, 32'h4, 32'h0, 4'h0, 0);
      // back-to-back write/read
      do_xfer(1, 32'hC, 32'hA5A5_0F0F, 4'hF, 0);
      do_xfer(0, 32'hC, 32'h0, 4'h0, 0);
      // abort on completion edge, address change mid-access
      do_xfer(1, 32'hC, 32'h0BAD_0BAD, 4'hF, 2);
      do_xfer(1, 32'h8, 32'h0BAD_0BAD, 4'hF, 3);
      do_xfer(0, 32'hC, 32'h0, 4'h0, 0);
      do_xfer(0, 32'h8, 32'h0, 4'h0, 0);

      // psel+penable in IDLE without a setup is ignored
      idle(1);
      psel    = 1'b1;
      penable = 1'b1;
      pwrite  = 1'b1;
      paddr   = 32'h4;
      pwdata  = 32'hFFFF_FFFF;
      pstrb   = 4'hF;
      repeat (3) begin
         @(posedge pclk); #1;
      end
      idle(1);
      do_xfer(0, 32'h4, 32'h0, 4'h0, 0);

      // reset in the middle of a write
      do_xfer(1, 32'h4, 32'hCAFE_F00D, 4'hF, 0);
      psel    = 1'b1;
      penable = 1'b0;
      pwrite  = 1'b1;
      paddr   = 32'h4;
      pwdata  = 32'h1234_5678;
      pstrb   = 4'hF;
      @(posedge pclk); #1;
      penable = 1'b1;
      preset  = 1'b1;
      @(posedge pclk); #1;
      preset  = 1'b0;
      psel    = 1'b0;
      penable = 1'b0;
      for (int i = 0; i < NR; i++) model[i] = 32'd0;
      @(negedge pclk);
      check("midrst_pready", {31'd0, pready}, 32'd0);
      check("midrst_pslverr", {31'd0, pslverr}, 32'd0);
      check("midrst_prdata", prdata, 32'd0);
      @(posedge pclk); #1;
      do_xfer(0, 32'h4, 32'h0, 4'h0, 0);
      do_xfer(0, 32'h8, 32'h0, 4'h0, 0);

      // random traffic
      for (int k = 0; k < 300; k++) begin
         r = $urandom_range(0, 9);
         if (r <= 6)      a = 32'($urandom_range(0, NR - 1)) << 2;
         else if (r == 7) a = (32'($urandom_range(0, NR - 1)) << 2) | 32'($urandom_range(1, 3));
         else if (r == 8) a = 32'($urandom_range(NR, NR + 15)) << 2;
         else             a = $urandom;
         r = $urandom_range(0, 9);
         if (r <= 6)      m = 0;
         else if (r == 7) m = 1;
         else if (r == 8) m = 2;
         else             m = 3;
         do_xfer(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), m);
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end

      // final read-back of every register
      for (int i = 0; i < NR; i++) do_xfer(0, 32'(i) << 2, 32'h0, 4'h0, 0);

      idle(3);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
